// File: rtl/dir_debounce.sv
// Direction switch conditioner: two-flop synchroniser followed by a four-state
// debounce FSM. Produces a clean level for the PIO, registered one-cycle edge
// pulses and a saturating count of rejected transitions.
module dir_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter bit          RESET_LEVEL     = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dir_raw,
  output logic       dir_out,
  output logic       dir_rise,
  output logic       dir_fall,
  output logic [7:0] glitch_count
);

  typedef enum logic [1:0] {
    StStableLo = 2'd0,
    StWaitHi   = 2'd1,
    StStableHi = 2'd2,
    StWaitLo   = 2'd3
  } state_e;

  localparam state_e StReset = RESET_LEVEL ? StStableHi : StStableLo;
  // Last count value before a new level is accepted.
  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1_q, sync2_q;
  logic                 raw_s;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 dir_out_q, dir_out_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [7:0]           glitch_q, glitch_d;
  logic [7:0]           glitch_inc;

  assign raw_s = sync2_q;

  // Synchroniser: only sync2_q is ever read by the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
    end else begin
      sync1_q <= dir_raw;
      sync2_q <= sync1_q;
    end
  end

  // Saturating increment of the rejected-transition counter.
  always_comb begin
    glitch_inc = glitch_q;
    if (glitch_q != 8'hFF) begin
      glitch_inc = glitch_q + 8'd1;
    end
  end

  // Debounce next-state, counter and output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_out_d = dir_out_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    glitch_d  = glitch_q;
    case (state_q)
      StStableLo: begin
        if (raw_s) begin
          state_d = StWaitHi;
          cnt_d   = '0;
        end
      end
      StWaitHi: begin
        if (!raw_s) begin
          state_d  = StStableLo;
          glitch_d = glitch_inc;
        end else if (cnt_q == CntLast) begin
          state_d   = StStableHi;
          dir_out_d = 1'b1;
          rise_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      StStableHi: begin
        if (!raw_s) begin
          state_d = StWaitLo;
          cnt_d   = '0;
        end
      end
      StWaitLo: begin
        if (raw_s) begin
          state_d  = StStableHi;
          glitch_d = glitch_inc;
        end else if (cnt_q == CntLast) begin
          state_d   = StStableLo;
          dir_out_d = 1'b0;
          fall_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = StReset;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, counter and registered outputs; reset discards any partial count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StReset;
      cnt_q     <= '0;
      dir_out_q <= RESET_LEVEL;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      glitch_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_out_q <= dir_out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      glitch_q  <= glitch_d;
    end
  end

  assign dir_out      = dir_out_q;
  assign dir_rise     = rise_q;
  assign dir_fall     = fall_q;
  assign glitch_count = glitch_q;

endmodule

// File: tb/tb_dir_debounce.sv
// Bench for dir_debounce: directed latency/glitch/saturation/reset scenarios
// plus random level runs, all checked against a run-length reference model.
module tb_dir_debounce;

  localparam int unsigned N = 4;

  logic       clk;
  logic       reset_n;
  logic       dir_raw;
  logic       dir_out;
  logic       dir_rise;
  logic       dir_fall;
  logic [7:0] glitch_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: synchroniser delay line, accepted level, length of
  // the current run of raw_s differing from the level, diagnostics.
  logic m_s1, m_s2, m_level, m_rise, m_fall;
  int   m_run, m_glitch;

  int ecount, last_rise_edge, last_fall_edge, rise_total, fall_total;

  dir_debounce #(
    .DEBOUNCE_CYCLES(N),
    .CNT_WIDTH      (16),
    .RESET_LEVEL    (1'b0)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dir_raw     (dir_raw),
    .dir_out     (dir_out),
    .dir_rise    (dir_rise),
    .dir_fall    (dir_fall),
    .glitch_count(glitch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0;
    m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_glitch = 0;
  endtask

  // A level must be seen N+1 consecutive edges at raw_s (one to arm, N to count)
  // before it is accepted; any earlier reversion is a glitch.
  task automatic model_edge(input logic raw);
    logic r;
    r = m_s2;
    m_s2 = m_s1;
    m_s1 = raw;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (r != m_level) begin
      m_run++;
      if (m_run == int'(N) + 1) begin
        m_level = r;
        m_run = 0;
        if (r) m_rise = 1'b1;
        else m_fall = 1'b1;
      end
    end else begin
      if (m_run > 0) m_glitch = (m_glitch < 255) ? m_glitch + 1 : 255;
      m_run = 0;
    end
  endtask

  task automatic compare_all();
    check("dir_out", 32'(dir_out), 32'(m_level));
    check("dir_rise", 32'(dir_rise), 32'(m_rise));
    check("dir_fall", 32'(dir_fall), 32'(m_fall));
    check("glitch_count", 32'(glitch_count), 32'(m_glitch));
    check("pulse_excl", 32'(dir_rise & dir_fall), 32'd0);
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge,
  // sample 1 ns later.
  task automatic tick(input logic raw, input logic rst);
    @(negedge clk);
    dir_raw = raw;
    reset_n = rst;
    if (!rst) model_reset();
    @(posedge clk);
    if (rst) model_edge(raw);
    ecount++;
    #1;
    compare_all();
    if (dir_rise) begin last_rise_edge = ecount; rise_total++; end
    if (dir_fall) begin last_fall_edge = ecount; fall_total++; end
  endtask

  task automatic clear_marks();
    ecount = -1; last_rise_edge = -1; last_fall_edge = -1;
    rise_total = 0; fall_total = 0;
  endtask

  initial begin
    int lvl, len;
    reset_n = 1'b0;
    dir_raw = 1'b1;
    model_reset();
    clear_marks();
    #3;
    check("rst_dir_out", 32'(dir_out), 32'd0);
    check("rst_rise", 32'(dir_rise), 32'd0);
    check("rst_fall", 32'(dir_fall), 32'd0);
    check("rst_glitch", 32'(glitch_count), 32'd0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);

    // Release with dir_raw high: accepted at edge N+2.
    clear_marks();
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
    check("rel_rise_edge", 32'(last_rise_edge), 32'(N + 2));
    check("rel_rise_cnt", 32'(rise_total), 32'd1);
    check("rel_dir_out", 32'(dir_out), 32'd1);

    // Clean falling edge.
    clear_marks();
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
    check("fall_edge", 32'(last_fall_edge), 32'(N + 2));
    check("fall_cnt", 32'(fall_total), 32'd1);

    // 1-cycle and 3-cycle glitches.
    clear_marks();
    tick(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1);
    check("glitch_two", 32'(glitch_count), 32'd2);
    check("glitch_no_pulse", 32'(rise_total + fall_total), 32'd0);
    check("glitch_dir_out", 32'(dir_out), 32'd0);

    // Bounce train then stable high.
    clear_marks();
    for (int b = 0; b < 5; b++) begin
      tick(1'b1, 1'b1); tick(1'b1, 1'b1);
      tick(1'b0, 1'b1); tick(1'b0, 1'b1);
    end
    check("bounce_no_rise", 32'(rise_total), 32'd0);
    clear_marks();
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
    check("bounce_rise_edge", 32'(last_rise_edge), 32'(N + 2));
    check("bounce_rise_cnt", 32'(rise_total), 32'd1);
    check("bounce_glitch", 32'(glitch_count), 32'd7);

    // Random level runs of 1..9 cycles.
    for (int s = 0; s < 250; s++) begin
      lvl = $urandom_range(0, 1);
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) tick(lvl[0], 1'b1);
    end

    // Saturation: 300 rejected glitches from a fresh reset.
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    for (int g = 0; g < 300; g++) begin
      tick(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    end
    check("sat_255", 32'(glitch_count), 32'd255);
    for (int g = 0; g < 20; g++) begin
      tick(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    end
    check("sat_hold", 32'(glitch_count), 32'd255);

    // Asynchronous reset while in WAIT_HI with cnt=2.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    clear_marks();
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("midrst_dir_out", 32'(dir_out), 32'd0);
    check("midrst_rise", 32'(dir_rise), 32'd0);
    check("midrst_glitch", 32'(glitch_count), 32'd0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("midrst_no_rise", 32'(rise_total), 32'd0);
    clear_marks();
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
    check("midrst_rise_edge", 32'(last_rise_edge), 32'(N + 2));
    check("midrst_rise_cnt", 32'(rise_total), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
